// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the multicycle control unit.
//   estado_e  - FSM state encodings (also the debug estado output)
//   Op*       - opcode constants (instruction[31:26])
//   Alu*      - aluop codes (3 bits, zero-extended at the top level)
//   Srcb*     - alusrcb select codes
//   Pc*       - pcsrc select codes
//   ctrl_t    - bundle of datapath controls produced by uc_salidas
package uc_pkg;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StIExec  = 4'd9,
      StIWb    = 4'd10,
      StJump   = 4'd11
   } estado_e;

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   localparam logic [2:0] AluAdd   = 3'b000;
   localparam logic [2:0] AluSub   = 3'b001;
   localparam logic [2:0] AluFunct = 3'b010;
   localparam logic [2:0] AluAnd   = 3'b100;
   localparam logic [2:0] AluOr    = 3'b101;
   localparam logic [2:0] AluSlt   = 3'b110;

   localparam logic [1:0] SrcbReg   = 2'b00;
   localparam logic [1:0] SrcbFour  = 2'b01;
   localparam logic [1:0] SrcbImm   = 2'b10;
   localparam logic [1:0] SrcbImmSh = 2'b11;

   localparam logic [1:0] PcAlu    = 2'b00;
   localparam logic [1:0] PcAluOut = 2'b01;
   localparam logic [1:0] PcJump   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       irwrite;
      logic       er;
      logic       ew;
      logic       regdst;
      logic       regwrite;
      logic       memtoreg;
      logic       alusrca;
      logic       illegal;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
   } ctrl_t;

   // State that follows DECODE; StFetch means the opcode is unsupported.
   function automatic estado_e decode_next(input logic [5:0] opcode, input bit en_jump);
      estado_e nxt;
      case (opcode)
         OpLw, OpSw:                     nxt = StMemAdr;
         OpRType:                        nxt = StExec;
         OpBeq:                          nxt = StBranch;
         OpBne:                          nxt = en_jump ? StBranch : StFetch;
         OpAddi, OpAndi, OpOri, OpSlti:  nxt = StIExec;
         OpJ:                            nxt = en_jump ? StJump : StFetch;
         default:                        nxt = StFetch;
      endcase
      return nxt;
   endfunction

   // ALU operation for an immediate-type instruction.
   function automatic logic [2:0] aluop_imm(input logic [5:0] op);
      logic [2:0] a;
      case (op)
         OpAndi:  a = AluAnd;
         OpOri:   a = AluOr;
         OpSlti:  a = AluSlt;
         default: a = AluAdd;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/uc_salidas.sv
// uc_salidas: combinational state-to-controls decoder.
//   estado    in  current FSM state
//   op        in  opcode latched in DECODE
//   opcode    in  live opcode (only looked at in DECODE, for illegal)
//   mem_ready in  memory handshake (FETCH write enables)
//   zero      in  ALU zero flag (BRANCH only)
//   ctrl      out control bundle; all zero unless set for the state
module uc_salidas
   import uc_pkg::*;
#(
   parameter bit EN_JUMP = 1'b1
) (
   input  estado_e      estado,
   input  logic  [5:0]  op,
   input  logic  [5:0]  opcode,
   input  logic         mem_ready,
   input  logic         zero,
   output ctrl_t        ctrl
);

   always_comb begin
      ctrl = '0;
      case (estado)
         StFetch: begin
            ctrl.er      = 1'b1;
            ctrl.alusrcb = SrcbFour;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         StDecode: begin
            ctrl.alusrcb = SrcbImmSh;
            ctrl.illegal = (decode_next(opcode, EN_JUMP) == StFetch);
         end
         StMemAdr: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SrcbImm;
         end
         StMemRd: begin
            ctrl.er   = 1'b1;
            ctrl.iord = 1'b1;
         end
         StMemWb: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StMemWr: begin
            ctrl.ew   = 1'b1;
            ctrl.iord = 1'b1;
         end
         StExec: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = AluFunct;
         end
         StAluWb: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         StBranch: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = AluSub;
            ctrl.pcsrc   = PcAluOut;
            // Raised only when the branch is taken, so the datapath need not
            // distinguish beq from bne.
            ctrl.pcwritecond = ((op == OpBeq) && zero) ||
                               ((op == OpBne) && !zero && EN_JUMP);
         end
         StIExec: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SrcbImm;
            ctrl.aluop   = aluop_imm(op);
         end
         StIWb: begin
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = aluop_imm(op);
         end
         StJump: begin
            ctrl.pcsrc   = PcJump;
            ctrl.pcwrite = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle MIPS-style control unit (Moore FSM).
//   clk, rst            clock, asynchronous active-high reset
//   opcode              instruction[31:26], sampled in DECODE
//   mem_ready           memory access completes when 1
//   zero                ALU zero flag, used in BRANCH
//   pcwrite .. alusrca  1-bit datapath controls
//   alusrcb, pcsrc      2-bit selects
//   aluop               ALU operation, zero-extended to ALUOP_W
//   estado              current state (debug)
//   illegal             one-cycle pulse on an unsupported opcode
module uc_multiciclo
   import uc_pkg::*;
#(
   parameter int unsigned ALUOP_W = 3,
   parameter bit          EN_JUMP = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   input  logic               zero,
   output logic               pcwrite,
   output logic               pcwritecond,
   output logic               iord,
   output logic               irwrite,
   output logic               er,
   output logic               ew,
   output logic               regdst,
   output logic               regwrite,
   output logic               memtoreg,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic [3:0]         estado,
   output logic               illegal
);

   if (ALUOP_W < 3) begin : g_aluop_w_check
      $error("uc_multiciclo: ALUOP_W must be at least 3");
   end

   estado_e    state_q;
   logic [5:0] op_q;
   ctrl_t      dec;
   ctrl_t      ctrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         op_q    <= '0;
      end else begin
         case (state_q)
            StFetch:  if (mem_ready) state_q <= StDecode;
            StDecode: begin
               op_q    <= opcode;
               state_q <= decode_next(opcode, EN_JUMP);
            end
            StMemAdr: state_q <= (op_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_q <= StMemWb;
            StMemWb:  state_q <= StFetch;
            StMemWr:  if (mem_ready) state_q <= StFetch;
            StExec:   state_q <= StAluWb;
            StAluWb:  state_q <= StFetch;
            StBranch: state_q <= StFetch;
            StIExec:  state_q <= StIWb;
            StIWb:    state_q <= StFetch;
            StJump:   state_q <= StFetch;
            default:  state_q <= StFetch;
         endcase
      end
   end

   uc_salidas #(
      .EN_JUMP (EN_JUMP)
   ) u_salidas (
      .estado    (state_q),
      .op        (op_q),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .zero      (zero),
      .ctrl      (dec)
   );

   // Reset forces every control low at once so an aborted write never lands.
   assign ctrl = rst ? '0 : dec;

   assign pcwrite     = ctrl.pcwrite;
   assign pcwritecond = ctrl.pcwritecond;
   assign iord        = ctrl.iord;
   assign irwrite     = ctrl.irwrite;
   assign er          = ctrl.er;
   assign ew          = ctrl.ew;
   assign regdst      = ctrl.regdst;
   assign regwrite    = ctrl.regwrite;
   assign memtoreg    = ctrl.memtoreg;
   assign alusrca     = ctrl.alusrca;
   assign alusrcb     = ctrl.alusrcb;
   assign pcsrc       = ctrl.pcsrc;
   assign aluop       = ALUOP_W'(ctrl.aluop);
   assign illegal     = ctrl.illegal;
   assign estado      = state_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: directed bench for uc_multiciclo. Two instances share
// stimulus: u_dut (EN_JUMP=1) and u_dut_nj (EN_JUMP=0).
// Output vector layout, MSB first:
//   pcwrite pcwritecond iord irwrite er ew regdst regwrite memtoreg alusrca
//   _ alusrcb[1:0] _ pcsrc[1:0] _ aluop[2:0] _ illegal
module tb_uc_multiciclo;

   typedef struct packed {
      logic        mr;
      logic        z;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [17:0] o;
   } vec_t;

   localparam logic [17:0] OFETCH  = 18'b1001100000_01_00_000_0;
   localparam logic [17:0] OFETCH0 = 18'b0000100000_01_00_000_0;
   localparam logic [17:0] ODEC    = 18'b0000000000_11_00_000_0;
   localparam logic [17:0] ODECI   = 18'b0000000000_11_00_000_1;
   localparam logic [17:0] OMADR   = 18'b0000000001_10_00_000_0;
   localparam logic [17:0] OMRD    = 18'b0010100000_00_00_000_0;
   localparam logic [17:0] OMWB    = 18'b0000000110_00_00_000_0;
   localparam logic [17:0] OMWR    = 18'b0010010000_00_00_000_0;
   localparam logic [17:0] OEXEC   = 18'b0000000001_00_00_010_0;
   localparam logic [17:0] OAWB    = 18'b0000001100_00_00_000_0;
   localparam logic [17:0] OIEXO   = 18'b0000000001_10_00_101_0;
   localparam logic [17:0] OIWBO   = 18'b0000000100_00_00_101_0;
   localparam logic [17:0] OIEXA   = 18'b0000000001_10_00_100_0;
   localparam logic [17:0] OIWBA   = 18'b0000000100_00_00_100_0;
   localparam logic [17:0] OIEXS   = 18'b0000000001_10_00_110_0;
   localparam logic [17:0] OIWBS   = 18'b0000000100_00_00_110_0;
   localparam logic [17:0] OBRT    = 18'b0100000001_00_01_001_0;
   localparam logic [17:0] OBRN    = 18'b0000000001_00_01_001_0;
   localparam logic [17:0] OJMP    = 18'b1000000000_00_10_000_0;

   logic clk, rst, mem_ready, zero;
   logic [5:0] opcode;

   logic pcwrite, pcwritecond, iord, irwrite, er, ew, regdst, regwrite, memtoreg, alusrca;
   logic illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluop;
   logic [3:0] estado;

   logic pcwrite_nj, pcwritecond_nj, iord_nj, irwrite_nj, er_nj, ew_nj, regdst_nj;
   logic regwrite_nj, memtoreg_nj, alusrca_nj, illegal_nj;
   logic [1:0] alusrcb_nj, pcsrc_nj;
   logic [2:0] aluop_nj;
   logic [3:0] estado_nj;

   logic [17:0] outs, outs_nj;
   assign outs = {pcwrite, pcwritecond, iord, irwrite, er, ew, regdst, regwrite, memtoreg,
                  alusrca, alusrcb, pcsrc, aluop, illegal};
   assign outs_nj = {pcwrite_nj, pcwritecond_nj, iord_nj, irwrite_nj, er_nj, ew_nj,
                     regdst_nj, regwrite_nj, memtoreg_nj, alusrca_nj, alusrcb_nj, pcsrc_nj,
                     aluop_nj, illegal_nj};

   int errors = 0;
   int checks = 0;

   uc_multiciclo #(.ALUOP_W(3), .EN_JUMP(1'b1)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .irwrite(irwrite),
      .er(er), .ew(ew), .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
      .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
      .estado(estado), .illegal(illegal)
   );

   uc_multiciclo #(.ALUOP_W(3), .EN_JUMP(1'b0)) u_dut_nj (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
      .pcwrite(pcwrite_nj), .pcwritecond(pcwritecond_nj), .iord(iord_nj),
      .irwrite(irwrite_nj), .er(er_nj), .ew(ew_nj), .regdst(regdst_nj),
      .regwrite(regwrite_nj), .memtoreg(memtoreg_nj), .alusrca(alusrca_nj),
      .alusrcb(alusrcb_nj), .pcsrc(pcsrc_nj), .aluop(aluop_nj), .estado(estado_nj),
      .illegal(illegal_nj)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; zero = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({estado, outs} !== {4'd0, 18'd0}) begin
            errors++;
            $display("FAIL reset[%0d]: estado=%0d outs=%b, want 0 / all zero", i, estado, outs);
         end
         checks++;
         if ({estado_nj, outs_nj} !== {4'd0, 18'd0}) begin
            errors++;
            $display("FAIL reset_nj[%0d]: estado=%0d outs=%b, want 0 / all zero",
                     i, estado_nj, outs_nj);
         end
         tick();
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({estado, outs} !== {4'd0, OFETCH}) begin
         errors++;
         $display("FAIL reset_release: estado=%0d outs=%b, want 0 %b", estado, outs, OFETCH);
      end
   endtask

   task automatic test_lw();
      vec_t v [6] = '{
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b0, 6'b100011, 4'd1, ODEC},
         '{1'b1, 1'b0, 6'b101011, 4'd2, OMADR},
         '{1'b1, 1'b0, 6'b000000, 4'd3, OMRD},
         '{1'b1, 1'b0, 6'b000000, 4'd4, OMWB},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH}};
      for (int i = 0; i < 6; i++) begin
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL lw[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         if (i < 5) tick();
      end
   endtask

   task automatic test_sw_wait();
      vec_t v [8] = '{
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b0, 6'b101011, 4'd1, ODEC},
         '{1'b1, 1'b0, 6'b100011, 4'd2, OMADR},
         '{1'b0, 1'b0, 6'b000000, 4'd5, OMWR},
         '{1'b0, 1'b0, 6'b000000, 4'd5, OMWR},
         '{1'b0, 1'b0, 6'b000000, 4'd5, OMWR},
         '{1'b1, 1'b0, 6'b000000, 4'd5, OMWR},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH}};
      for (int i = 0; i < 8; i++) begin
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL sw_wait[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         if (i < 7) tick();
      end
   endtask

   task automatic test_rtype();
      vec_t v [6] = '{
         '{1'b0, 1'b0, 6'b000000, 4'd0, OFETCH0},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b0, 6'b000000, 4'd1, ODEC},
         '{1'b1, 1'b0, 6'b100011, 4'd6, OEXEC},
         '{1'b1, 1'b0, 6'b000000, 4'd7, OAWB},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH}};
      for (int i = 0; i < 6; i++) begin
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL rtype[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         if (i < 5) tick();
      end
   endtask

   // ori, andi, slti back to back.
   task automatic test_itype();
      vec_t v [13] = '{
         '{1'b1, 1'b0, 6'b000000, 4'd0,  OFETCH},
         '{1'b1, 1'b0, 6'b001101, 4'd1,  ODEC},
         '{1'b1, 1'b0, 6'b001000, 4'd9,  OIEXO},
         '{1'b1, 1'b0, 6'b001100, 4'd10, OIWBO},
         '{1'b1, 1'b0, 6'b000000, 4'd0,  OFETCH},
         '{1'b1, 1'b0, 6'b001100, 4'd1,  ODEC},
         '{1'b1, 1'b0, 6'b001101, 4'd9,  OIEXA},
         '{1'b1, 1'b0, 6'b000000, 4'd10, OIWBA},
         '{1'b1, 1'b0, 6'b000000, 4'd0,  OFETCH},
         '{1'b1, 1'b0, 6'b001010, 4'd1,  ODEC},
         '{1'b1, 1'b0, 6'b000000, 4'd9,  OIEXS},
         '{1'b1, 1'b0, 6'b000000, 4'd10, OIWBS},
         '{1'b1, 1'b0, 6'b000000, 4'd0,  OFETCH}};
      for (int i = 0; i < 13; i++) begin
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL itype[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         if (i < 12) tick();
      end
   endtask

   // beq z=1 taken, bne z=1 not taken, bne z=0 taken, beq z=0 not taken.
   task automatic test_branch();
      vec_t v [13] = '{
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b0, 6'b000100, 4'd1, ODEC},
         '{1'b1, 1'b1, 6'b000101, 4'd8, OBRT},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b0, 6'b000101, 4'd1, ODEC},
         '{1'b1, 1'b1, 6'b000100, 4'd8, OBRN},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b1, 6'b000101, 4'd1, ODEC},
         '{1'b1, 1'b0, 6'b000000, 4'd8, OBRT},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b1, 6'b000100, 4'd1, ODEC},
         '{1'b1, 1'b0, 6'b000101, 4'd8, OBRN},
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH}};
      for (int i = 0; i < 13; i++) begin
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL branch[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         if (i < 12) tick();
      end
   endtask

   task automatic test_illegal();
      vec_t v [3] = '{
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b0, 6'b111111, 4'd1, ODECI},
         '{1'b1, 1'b0, 6'b111111, 4'd0, OFETCH}};
      for (int i = 0; i < 3; i++) begin
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL illegal[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         if (i < 2) tick();
      end
   endtask

   // lw aborted by reset while in MEMWB.
   task automatic test_reset_mid();
      vec_t v [5] = '{
         '{1'b1, 1'b0, 6'b000000, 4'd0, OFETCH},
         '{1'b1, 1'b0, 6'b100011, 4'd1, ODEC},
         '{1'b1, 1'b0, 6'b000000, 4'd2, OMADR},
         '{1'b1, 1'b0, 6'b000000, 4'd3, OMRD},
         '{1'b1, 1'b0, 6'b000000, 4'd4, OMWB}};
      for (int i = 0; i < 5; i++) begin
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL reset_mid[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         if (i < 4) tick();
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({estado, outs} !== {4'd0, 18'd0}) begin
         errors++;
         $display("FAIL reset_mid_async: estado=%0d outs=%b, want 0 / all zero", estado, outs);
      end
      tick();
      #1;
      checks++;
      if ({estado, outs} !== {4'd0, 18'd0}) begin
         errors++;
         $display("FAIL reset_mid_held: estado=%0d outs=%b, want 0 / all zero", estado, outs);
      end
      rst = 1'b0; opcode = 6'b000000;
      #1;
      checks++;
      if ({estado, outs} !== {4'd0, OFETCH}) begin
         errors++;
         $display("FAIL reset_mid_release: estado=%0d outs=%b, want 0 %b", estado, outs, OFETCH);
      end
      tick();
      checks++;
      if (estado !== 4'd1) begin
         errors++;
         $display("FAIL reset_mid_first_edge: estado=%0d, want 1", estado);
      end
   endtask

   // j then bne on both instances, each from a fresh reset.
   task automatic test_jump();
      vec_t v [6] = '{
         '{1'b1, 1'b0, 6'b000000, 4'd0,  OFETCH},
         '{1'b1, 1'b0, 6'b000010, 4'd1,  ODEC},
         '{1'b1, 1'b0, 6'b000000, 4'd11, OJMP},
         '{1'b1, 1'b0, 6'b000000, 4'd0,  OFETCH},
         '{1'b1, 1'b0, 6'b000101, 4'd1,  ODEC},
         '{1'b1, 1'b0, 6'b000000, 4'd8,  OBRT}};
      logic [21:0] w [6] = '{
         {4'd0, OFETCH}, {4'd1, ODECI}, {4'd0, OFETCH},
         {4'd0, OFETCH}, {4'd1, ODECI}, {4'd0, OFETCH}};
      for (int i = 0; i < 6; i++) begin
         if (i == 0 || i == 3) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         mem_ready = v[i].mr; zero = v[i].z; opcode = v[i].op;
         #1;
         checks++;
         if ({estado, outs} !== {v[i].st, v[i].o}) begin
            errors++;
            $display("FAIL jump[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado, outs, v[i].st, v[i].o);
         end
         checks++;
         if ({estado_nj, outs_nj} !== w[i]) begin
            errors++;
            $display("FAIL jump_nj[%0d]: estado=%0d outs=%b, want estado=%0d outs=%b",
                     i, estado_nj, outs_nj, w[i][21:18], w[i][17:0]);
         end
         if (i != 2 && i != 5) tick();
      end
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'b000000;
      test_reset();
      test_lw();
      test_sw_wait();
      test_rtype();
      test_itype();
      test_branch();
      test_illegal();
      test_reset_mid();
      test_jump();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
